// File: rtl/rptr_prefetch_ctrl.sv
// Read-side controller of the asynchronous FIFO: read pointers, empty/level flags,
// memory read issue and a 2-entry first-word-fall-through output buffer.
module rptr_prefetch_ctrl #(
  parameter int unsigned PTR_WIDTH  = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [PTR_WIDTH:0]    g_wptr_sync,
  output logic                  mem_rd_en,
  output logic [PTR_WIDTH-1:0]  raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [PTR_WIDTH:0]    b_rptr,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    rd_level
);

  typedef logic [PTR_WIDTH:0]    ptr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam ptr_t AE_PTR = ptr_t'(AE_LEVEL);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  buf_state_t buf_state;
  buf_state_t buf_next;

  logic  inflight;
  logic  pop;
  logic  issue;
  logic  [1:0] occ;
  logic  [1:0] occ_after_pop;
  ptr_t  b_rptr_next;
  ptr_t  g_rptr_next;
  ptr_t  wbin;
  ptr_t  level_next;
  word_t entry0;
  word_t entry1;

  // ---------------------------------------------------------------------------
  // Issue decision and pointer arithmetic
  // ---------------------------------------------------------------------------
  assign pop           = m_valid & m_ready;
  assign occ           = 2'(buf_state) + {1'b0, inflight};
  assign occ_after_pop = occ - {1'b0, pop};
  assign issue         = ~empty & ~rrst & (occ_after_pop < 2'd2);

  assign mem_rd_en   = issue;
  assign raddr       = b_rptr[PTR_WIDTH-1:0];
  assign b_rptr_next = b_rptr + ptr_t'(issue);
  assign g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wbin = '0;
    for (int i = 0; i <= int'(PTR_WIDTH); i++) begin
      wbin[i] = ^(g_wptr_sync >> i);
    end
  end

  assign level_next = wbin - b_rptr_next;

  // ---------------------------------------------------------------------------
  // Pointers and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge rclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process order.
    if (rrst) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      inflight     <= 1'b0;
    end else begin
      b_rptr       <= b_rptr_next;
      g_rptr       <= g_rptr_next;
      empty        <= (g_rptr_next == g_wptr_sync);
      almost_empty <= (level_next <= AE_PTR);
      rd_level     <= level_next;
      inflight     <= issue;
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer occupancy FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge rclk) begin
    if (rrst) begin
      buf_state <= BUF_EMPTY;
    end else begin
      buf_state <= buf_next;
    end
  end

  always_comb begin
    buf_next = buf_state;
    unique case (buf_state)
      BUF_EMPTY: begin
        if (inflight) buf_next = BUF_ONE;
      end
      BUF_ONE: begin
        if (inflight && !pop)      buf_next = BUF_TWO;
        else if (!inflight && pop) buf_next = BUF_EMPTY;
      end
      BUF_TWO: begin
        if (pop && !inflight) buf_next = BUF_ONE;
      end
      default: buf_next = BUF_EMPTY;
    endcase
  end

  always_comb begin
    m_valid = (buf_state != BUF_EMPTY);
    m_data  = entry0;
  end

  // Head lives in entry0; a word arriving alongside a pop of the only entry
  // becomes the new head directly.
  always_ff @(posedge rclk) begin
    // NOTE: the two buffer entries are reset so m_data reads 0 out of reset;
    // a real memory array would be left unreset.
    if (rrst) begin
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      unique case (buf_state)
        BUF_EMPTY: begin
          if (inflight) entry0 <= rdata;
        end
        BUF_ONE: begin
          if (inflight && pop) entry0 <= rdata;
          else if (inflight)   entry1 <= rdata;
        end
        BUF_TWO: begin
          if (pop) begin
            entry0 <= entry1;
            if (inflight) entry1 <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rptr_prefetch_ctrl.sv
// Directed bench for rptr_prefetch_ctrl: memory model, pop scoreboard and
// a pointer/level monitor driven from a bench-side issue counter.
module tb_rptr_prefetch_ctrl;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [3:0] g_wptr_sync;
  logic       mem_rd_en;
  logic [2:0] raddr;
  logic [7:0] rdata;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [3:0] b_rptr;
  logic [3:0] g_rptr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_level;

  rptr_prefetch_ctrl #(.PTR_WIDTH(3), .DATA_WIDTH(8), .AE_LEVEL(1)) dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .g_wptr_sync  (g_wptr_sync),
    .mem_rd_en    (mem_rd_en),
    .raddr        (raddr),
    .rdata        (rdata),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .b_rptr       (b_rptr),
    .g_rptr       (g_rptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level)
  );

  always #5 rclk = ~rclk;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int rd_pulses = 0;
  logic lvl_chk_en = 1'b0;

  logic [7:0] mem [8];
  logic [7:0] exp_q [$];
  logic [3:0] wptr;
  logic [3:0] iss_cnt;
  logic [3:0] exp_level;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] to_bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Synchronous read port: data valid the cycle after the strobe.
  always @(posedge rclk) begin
    if (mem_rd_en === 1'b1) rdata <= mem[raddr];
  end

  // Bench-side read pointer: counts strobes, predicts next-cycle level.
  always @(posedge rclk) begin
    if (rrst === 1'b1) begin
      iss_cnt   = '0;
      exp_level = '0;
    end else begin
      if (mem_rd_en === 1'b1) iss_cnt = iss_cnt + 4'd1;
      exp_level = to_bin(g_wptr_sync) - iss_cnt;
    end
  end

  always @(negedge rclk) begin
    if (mem_rd_en === 1'b1) rd_pulses++;
    if (lvl_chk_en) begin
      check("b_rptr", b_rptr, iss_cnt);
      check("g_rptr", g_rptr, to_gray(iss_cnt));
      check("rd_level", rd_level, exp_level);
      check("almost_empty", almost_empty, (exp_level <= 4'd1));
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      pops++;
      check("pop_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) check("m_data_order", m_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wptr[2:0]] = d;
    exp_q.push_back(d);
    wptr = wptr + 4'd1;
  endtask

  // Leaves rrst released in the current cycle so the caller's writes land in cycle 0.
  task automatic do_reset();
    rrst        = 1'b1;
    m_ready     = 1'b0;
    wptr        = '0;
    g_wptr_sync = '0;
    exp_q.delete();
    tick();
    tick();
    rrst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic measure(input int cycles, output int run, output int gaps);
    bit seen_end = 1'b0;
    run  = 0;
    gaps = 0;
    repeat (cycles) begin
      @(negedge rclk);
      if (m_valid === 1'b1) begin
        if (seen_end) gaps++;
        run++;
      end else if (run > 0) begin
        seen_end = 1'b1;
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int run;
    int gaps;
    int p0;

    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Reset with a non-empty write pointer already present
    rrst        = 1'b1;
    m_ready     = 1'b0;
    wptr        = '0;
    for (int i = 0; i < 4; i++) push_word(8'h40 + 8'(i));
    g_wptr_sync = 4'b0110;
    tick();
    lvl_chk_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      check("rst_b_rptr", b_rptr, 4'd0);
      check("rst_g_rptr", g_rptr, 4'd0);
      check("rst_empty", empty, 1'b1);
      check("rst_almost_empty", almost_empty, 1'b1);
      check("rst_rd_level", rd_level, 4'd0);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, 8'h00);
      check("rst_mem_rd_en", mem_rd_en, 1'b0);
      if (c == 0) tick();
    end
    rrst = 1'b0;
    tick();
    check("post_rst_empty", empty, 1'b0);
    check("post_rst_level", rd_level, 4'd4);
    check("post_rst_rd_en", mem_rd_en, 1'b1);
    m_ready = 1'b1;
    drain(30);
    tick();
    check("post_rst_idle_empty", empty, 1'b1);

    // Single word: cold-start latency
    do_reset();
    m_ready = 1'b1;
    push_word(8'hA5);
    g_wptr_sync = to_gray(wptr);
    tick();
    check("single_rd_en_c1", mem_rd_en, 1'b1);
    check("single_raddr_c1", raddr, 3'd0);
    check("single_empty_c1", empty, 1'b0);
    tick();
    check("single_valid_c2", m_valid, 1'b0);
    tick();
    check("single_valid_c3", m_valid, 1'b1);
    check("single_data_c3", m_data, 8'hA5);
    tick();
    check("single_valid_c4", m_valid, 1'b0);
    check("single_empty_c4", empty, 1'b1);

    // Burst of 8 across the full depth
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
    g_wptr_sync = 4'b1100;
    measure(20, run, gaps);
    check("burst_run", run, 8);
    check("burst_gaps", gaps, 0);
    check("burst_b_rptr", b_rptr, 4'd8);
    check("burst_empty", empty, 1'b1);

    // Backpressure: only two reads run ahead of the stalled consumer
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'h20 + 8'(i));
    g_wptr_sync = to_gray(wptr);
    rd_pulses = 0;
    repeat (10) tick();
    check("bp_rd_pulses", rd_pulses, 2);
    check("bp_valid", m_valid, 1'b1);
    check("bp_head", m_data, 8'h20);
    m_ready = 1'b1;
    measure(15, run, gaps);
    check("bp_run", run, 5);
    check("bp_gaps", gaps, 0);
    check("bp_queue", exp_q.size(), 0);

    // Wrap-around with levels moving through the almost-empty threshold
    do_reset();
    m_ready = 1'b1;
    p0 = pops;
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < ((c == 6) ? 2 : 3); i++) push_word(8'h80 + 8'(c * 3 + i));
      g_wptr_sync = to_gray(wptr);
      repeat (5) tick();
    end
    drain(30);
    check("wrap_pops", pops - p0, 20);
    check("wrap_b_rptr", b_rptr, 4'd4);
    check("wrap_empty", empty, 1'b1);

    // Reset while one word is buffered and another is in flight
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'h50 + 8'(i));
    g_wptr_sync = to_gray(wptr);
    repeat (3) tick();
    check("mid_valid_pre", m_valid, 1'b1);
    check("mid_head_pre", m_data, 8'h50);
    rrst        = 1'b1;
    wptr        = '0;
    g_wptr_sync = '0;
    exp_q.delete();
    tick();
    check("mid_valid", m_valid, 1'b0);
    check("mid_b_rptr", b_rptr, 4'd0);
    check("mid_g_rptr", g_rptr, 4'd0);
    check("mid_m_data", m_data, 8'h00);
    check("mid_empty", empty, 1'b1);
    check("mid_rd_en", mem_rd_en, 1'b0);
    rrst = 1'b0;
    p0 = pops;
    push_word(8'hC0);
    push_word(8'hC1);
    g_wptr_sync = to_gray(wptr);
    m_ready = 1'b1;
    drain(20);
    repeat (4) tick();
    check("mid_after_pops", pops - p0, 2);

    lvl_chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
